// File: rtl/alu_wb_stage.sv
// Writeback stage for the 4-bit ALU: register file, Z/N/V flags, overflow counter and clear sequencer.
// Optional same-cycle write-through forwarding on both read ports when WB_BYPASS_EN is defined.
module alu_wb_stage #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 3,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_err,
    input  logic [1:0]        in_op,
    input  logic              clr_req,
    output logic              clr_busy,
    input  logic [ADDR_W-1:0] rs1_addr,
    output logic [DATA_W-1:0] rs1_data,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs2_data,
    output logic              flag_z,
    output logic              flag_n,
    output logic              flag_v,
    output logic [CNT_W-1:0]  ovf_cnt
);

    localparam int NREG = 2 ** ADDR_W;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    logic [DATA_W-1:0] regs [NREG];
    logic [0:0]        state;
    logic [ADDR_W-1:0] ptr;
    logic              accept;
    logic              arith_op;
    logic [DATA_W-1:0] rd1_arr;
    logic [DATA_W-1:0] rd2_arr;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign in_ready = (state == ST_IDLE);
    assign clr_busy = (state == ST_CLEAR);
    assign accept   = in_valid && in_ready;
    assign arith_op = ~in_op[1];

    // A clear request wins over the write's flag/counter update on the same edge;
    // the register write itself still lands and is wiped later by the sweep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            state   <= ST_IDLE;
            ptr     <= '0;
            flag_z  <= 1'b0;
            flag_n  <= 1'b0;
            flag_v  <= 1'b0;
            ovf_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept && (in_rd != '0)) regs[in_rd] <= in_data;
                    if (clr_req) begin
                        state   <= ST_CLEAR;
                        ptr     <= {{(ADDR_W-1){1'b0}}, 1'b1};
                        flag_z  <= 1'b0;
                        flag_n  <= 1'b0;
                        flag_v  <= 1'b0;
                        ovf_cnt <= '0;
                    end else if (accept) begin
                        flag_z <= (in_data == '0);
                        flag_n <= in_data[DATA_W-1];
                        if (arith_op) begin
                            flag_v <= in_err;
                            if (in_err) ovf_cnt <= sat_inc(ovf_cnt);
                        end
                    end
                end
                default: begin
                    regs[ptr] <= '0;
                    ptr       <= ptr + 1'b1;
                    if (ptr == '1) state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rd1_arr = (rs1_addr == '0) ? '0 : regs[rs1_addr];
    assign rd2_arr = (rs2_addr == '0) ? '0 : regs[rs2_addr];

`ifdef WB_BYPASS_EN
    assign rs1_data = (accept && (in_rd != '0) && (rs1_addr == in_rd)) ? in_data : rd1_arr;
    assign rs2_data = (accept && (in_rd != '0) && (rs2_addr == in_rd)) ? in_data : rd2_arr;
`else
    assign rs1_data = rd1_arr;
    assign rs2_data = rd2_arr;
`endif

endmodule

// File: tb/tb_alu_wb_stage.sv
// Bench for alu_wb_stage: writes, flags, saturating counter, clear sequencer and forwarding.
module tb_alu_wb_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready, in_ready_c;
    logic [2:0] in_rd;
    logic [3:0] in_data;
    logic       in_err;
    logic [1:0] in_op;
    logic       clr_req;
    logic       clr_busy, clr_busy_c;
    logic [2:0] rs1_addr, rs2_addr;
    logic [3:0] rs1_data, rs2_data, rs1_data_c, rs2_data_c;
    logic       flag_z, flag_n, flag_v, flag_z_c, flag_n_c, flag_v_c;
    logic [7:0] ovf_cnt;
    logic [1:0] ovf_cnt_c;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [2:0] addr;
        logic [3:0] data;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_wb_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_data(in_data), .in_err(in_err), .in_op(in_op),
        .clr_req(clr_req), .clr_busy(clr_busy),
        .rs1_addr(rs1_addr), .rs1_data(rs1_data), .rs2_addr(rs2_addr), .rs2_data(rs2_data),
        .flag_z(flag_z), .flag_n(flag_n), .flag_v(flag_v), .ovf_cnt(ovf_cnt)
    );

    alu_wb_stage #(.CNT_W(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_c),
        .in_rd(in_rd), .in_data(in_data), .in_err(in_err), .in_op(in_op),
        .clr_req(clr_req), .clr_busy(clr_busy_c),
        .rs1_addr(rs1_addr), .rs1_data(rs1_data_c), .rs2_addr(rs2_addr), .rs2_data(rs2_data_c),
        .flag_z(flag_z_c), .flag_n(flag_n_c), .flag_v(flag_v_c), .ovf_cnt(ovf_cnt_c)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic do_reset();
        rst_n = 1'b0; in_valid = 0; in_rd = 0; in_data = 0; in_err = 0; in_op = 0;
        clr_req = 0; rs1_addr = 0; rs2_addr = 0;
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One accepted write; expected read-back queued for later comparison.
    task automatic do_write(input logic [2:0] rd, input logic [3:0] d,
                            input logic [1:0] op, input logic e);
        @(negedge clk);
        in_valid = 1; in_rd = rd; in_data = d; in_op = op; in_err = e;
        @(posedge clk); #1;
        in_valid = 0;
        sb.push_back('{addr: rd, data: (rd == 3'd0) ? 4'h0 : d});
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0; in_valid = 0; clr_req = 0; rs1_addr = 3'd5; rs2_addr = 3'd7;
        #1;
        n_checks++;
        if (in_ready !== 1'b1 || clr_busy !== 1'b0) begin
            n_errors++; $display("FAIL reset_ctrl: in_ready=%b clr_busy=%b, want 1 0", in_ready, clr_busy);
        end
        n_checks++;
        if ({flag_z, flag_n, flag_v} !== 3'b000 || ovf_cnt !== 8'd0) begin
            n_errors++; $display("FAIL reset_flags: zn v=%b cnt=%0d, want 000 0", {flag_z, flag_n, flag_v}, ovf_cnt);
        end
        n_checks++;
        if (rs1_data !== 4'h0 || rs2_data !== 4'h0) begin
            n_errors++; $display("FAIL reset_regs: rs1=%h rs2=%h, want 0 0", rs1_data, rs2_data);
        end
        do_reset();
        e.addr = 0;
    endtask

    task automatic test_write();
        exp_t e;
        do_reset();
        do_write(3'd3, 4'hA, 2'b00, 1'b0);
        n_checks++;
        if (flag_n !== 1'b1 || flag_z !== 1'b0 || flag_v !== 1'b0) begin
            n_errors++; $display("FAIL write_flags: z=%b n=%b v=%b, want z0 n1 v0", flag_z, flag_n, flag_v);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front(); rs1_addr = e.addr; rs2_addr = e.addr; #1;
            n_checks++;
            if (rs1_data !== e.data || rs2_data !== e.data) begin
                n_errors++; $display("FAIL write_read R%0d: rs1=%h rs2=%h, want %h", e.addr, rs1_data, rs2_data, e.data);
            end
        end
        do_write(3'd0, 4'h5, 2'b00, 1'b0);
        n_checks++;
        if (flag_z !== 1'b0 || flag_n !== 1'b0) begin
            n_errors++; $display("FAIL r0_flags: z=%b n=%b, want z0 n0", flag_z, flag_n);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front(); rs1_addr = e.addr; #1;
            n_checks++;
            if (rs1_data !== e.data) begin
                n_errors++; $display("FAIL r0_read R%0d: got %h, want %h", e.addr, rs1_data, e.data);
            end
        end
        do_write(3'd4, 4'h0, 2'b10, 1'b0);
        n_checks++;
        if (flag_z !== 1'b1 || flag_n !== 1'b0) begin
            n_errors++; $display("FAIL zero_flag: z=%b n=%b, want z1 n0", flag_z, flag_n);
        end
        sb.delete();
    endtask

    task automatic test_ovf();
        exp_t e;
        do_write(3'd1, 4'h3, 2'b01, 1'b1);
        n_checks++;
        if (flag_v !== 1'b1 || ovf_cnt !== 8'd1) begin
            n_errors++; $display("FAIL sub_ovf: v=%b cnt=%0d, want v1 cnt1", flag_v, ovf_cnt);
        end
        do_write(3'd2, 4'h6, 2'b11, 1'b1);
        n_checks++;
        if (flag_v !== 1'b1 || ovf_cnt !== 8'd1) begin
            n_errors++; $display("FAIL xor_err_ignored: v=%b cnt=%0d, want v1 cnt1", flag_v, ovf_cnt);
        end
        do_write(3'd3, 4'h1, 2'b00, 1'b0);
        n_checks++;
        if (flag_v !== 1'b0 || ovf_cnt !== 8'd1) begin
            n_errors++; $display("FAIL add_noovf: v=%b cnt=%0d, want v0 cnt1", flag_v, ovf_cnt);
        end
        do_write(3'd4, 4'hC, 2'b10, 1'b0);
        n_checks++;
        if (flag_v !== 1'b0) begin
            n_errors++; $display("FAIL nand_hold_v: v=%b, want 0", flag_v);
        end
        while (sb.size() > 0) begin
            e = sb.pop_front(); rs2_addr = e.addr; #1;
            n_checks++;
            if (rs2_data !== e.data) begin
                n_errors++; $display("FAIL ovf_read R%0d: got %h, want %h", e.addr, rs2_data, e.data);
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 1; i <= 4; i++) do_write(3'(i), 4'(i + 4), 2'b00, 1'b1);
        n_checks++;
        if (ovf_cnt !== 8'd4) begin
            n_errors++; $display("FAIL cnt8: got %0d, want 4", ovf_cnt);
        end
        n_checks++;
        if (ovf_cnt_c !== 2'd3) begin
            n_errors++; $display("FAIL cnt2_sat: got %0d, want 3", ovf_cnt_c);
        end
        sb.delete();
    endtask

    task automatic test_clear();
        exp_t e;
        int cyc, viol, nz;
        do_reset();
        for (int i = 1; i <= 7; i++) do_write(3'(i), 4'(i + 8), 2'b00, 1'b1);
        while (sb.size() > 0) begin
            e = sb.pop_front(); rs1_addr = e.addr; #1;
            n_checks++;
            if (rs1_data !== e.data) begin
                n_errors++; $display("FAIL fill R%0d: got %h, want %h", e.addr, rs1_data, e.data);
            end
        end
        @(negedge clk); clr_req = 1;
        @(posedge clk); #1;
        clr_req = 0;
        in_valid = 1; in_rd = 3'd4; in_data = 4'hF; in_op = 2'b11; in_err = 0;
        cyc = 0; viol = 0;
        while (clr_busy && cyc < 20) begin
            cyc++;
            if (in_ready !== 1'b0) viol++;
            @(posedge clk); #1;
        end
        in_valid = 0;
        n_checks++;
        if (cyc != 7 || viol != 0) begin
            n_errors++; $display("FAIL clear_len: busy cycles=%0d ready_violations=%0d, want 7 0", cyc, viol);
        end
        nz = 0;
        for (int a = 0; a < 8; a++) begin
            rs1_addr = 3'(a); #1;
            if (rs1_data !== 4'h0) nz++;
        end
        n_checks++;
        if (nz != 0) begin
            n_errors++; $display("FAIL clear_regs: %0d nonzero entries, want 0", nz);
        end
        n_checks++;
        if ({flag_z, flag_n, flag_v} !== 3'b000 || ovf_cnt !== 8'd0) begin
            n_errors++; $display("FAIL clear_flags: znv=%b cnt=%0d, want 000 0", {flag_z, flag_n, flag_v}, ovf_cnt);
        end
    endtask

    task automatic test_simul();
        exp_t e;
        int cyc;
        do_write(3'd3, 4'h8, 2'b00, 1'b1);
        while (sb.size() > 0) begin
            e = sb.pop_front(); rs1_addr = e.addr; #1;
            n_checks++;
            if (rs1_data !== e.data || flag_n !== 1'b1 || ovf_cnt !== 8'd1) begin
                n_errors++; $display("FAIL pre_simul: R%0d=%h n=%b cnt=%0d, want %h 1 1", e.addr, rs1_data, flag_n, ovf_cnt, e.data);
            end
        end
        @(negedge clk);
        in_valid = 1; in_rd = 3'd5; in_data = 4'h7; in_op = 2'b00; in_err = 1; clr_req = 1;
        @(posedge clk); #1;
        in_valid = 0; clr_req = 0; rs1_addr = 3'd5;
        #1;
        n_checks++;
        if (clr_busy !== 1'b1 || rs1_data !== 4'h7) begin
            n_errors++; $display("FAIL simul_accept: busy=%b R5=%h, want 1 7", clr_busy, rs1_data);
        end
        n_checks++;
        if ({flag_z, flag_n, flag_v} !== 3'b000 || ovf_cnt !== 8'd0) begin
            n_errors++; $display("FAIL simul_flags: znv=%b cnt=%0d, want 000 0", {flag_z, flag_n, flag_v}, ovf_cnt);
        end
        cyc = 0;
        while (clr_busy && cyc < 20) begin
            cyc++; @(posedge clk); #1;
        end
        rs2_addr = 3'd3; #1;
        n_checks++;
        if (cyc != 7 || rs1_data !== 4'h0 || rs2_data !== 4'h0 || flag_z !== 1'b0 || flag_n !== 1'b0) begin
            n_errors++; $display("FAIL simul_post: cyc=%0d R5=%h R3=%h z=%b n=%b, want 7 0 0 0 0", cyc, rs1_data, rs2_data, flag_z, flag_n);
        end
    endtask

    task automatic test_reset_mid_clear();
        do_write(3'd6, 4'h5, 2'b00, 1'b0);
        sb.delete();
        @(negedge clk); clr_req = 1;
        @(posedge clk); #1; clr_req = 0;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b0; rs1_addr = 3'd6;
        #1;
        n_checks++;
        if (clr_busy !== 1'b0 || in_ready !== 1'b1 || rs1_data !== 4'h0) begin
            n_errors++; $display("FAIL reset_abort: busy=%b ready=%b R6=%h, want 0 1 0", clr_busy, in_ready, rs1_data);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_bypass();
        exp_t e;
        logic [3:0] want_same;
        do_write(3'd2, 4'h4, 2'b00, 1'b0);
        while (sb.size() > 0) begin
            e = sb.pop_front(); rs2_addr = e.addr; #1;
            n_checks++;
            if (rs2_data !== e.data) begin
                n_errors++; $display("FAIL byp_pre R%0d: got %h, want %h", e.addr, rs2_data, e.data);
            end
        end
`ifdef WB_BYPASS_EN
        want_same = 4'h9;
`else
        want_same = 4'h4;
`endif
        @(negedge clk);
        in_valid = 1; in_rd = 3'd2; in_data = 4'h9; in_op = 2'b11; in_err = 0; rs2_addr = 3'd2;
        #1;
        n_checks++;
        if (rs2_data !== want_same) begin
            n_errors++; $display("FAIL byp_same_cycle: got %h, want %h", rs2_data, want_same);
        end
        @(posedge clk); #1;
        in_valid = 0;
        n_checks++;
        if (rs2_data !== 4'h9) begin
            n_errors++; $display("FAIL byp_next_cycle: got %h, want 9", rs2_data);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_ovf();
        test_saturation();
        test_clear();
        test_simul();
        test_reset_mid_clear();
        test_bypass();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
